dcache_req_buffer: RTL and testbench

In-order request buffer sitting directly upstream of `dcache_interface`: it accepts memory operations from the exe/mem stage and queues them in a FIFO of `DEPTH` entries. It issues the head entry to the data cache with one request outstanding, reissues on nack, waits out replays, and returns one completion per request to write-back. On a pipeline flush it kills the outstanding access, drains its response and empties the queue.

---
 rtl/dcache_req_buffer.sv | 193 +++++++++++++++++++
 tb/tb_dcache_req_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_buffer.sv
// In-order request buffer in front of dcache_interface: queues exe/mem requests,
// issues the head one at a time, retries on nack and returns one completion each.
package dcache_req_buffer_pkg;
    typedef logic [63:0]  bus64_t;
    typedef logic [127:0] bus_simd_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_AMO   = 2'd2
    } mem_op_t;

    typedef struct packed {
        logic       valid;
        logic       kill;
        mem_op_t    op;
        logic [4:0] rd;
        logic [2:0] mem_size;
        bus64_t     data_rs1;
        bus64_t     data_rs2;
    } req_cpu_dcache_t;

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic       nack;
        logic       replay;
        logic [4:0] rd;
        bus_simd_t  data;
        logic       xcpt_ma_st;
        logic       xcpt_ma_ld;
        logic       xcpt_pf_st;
        logic       xcpt_pf_ld;
    } resp_dcache_cpu_t;
endpackage

module dcache_req_buffer
    import dcache_req_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_RETRY = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  req_cpu_dcache_t  req_i,
    input  logic             flush_i,
    output req_cpu_dcache_t  req_cpu_dcache_o,
    input  resp_dcache_cpu_t resp_dcache_cpu_i,
    output logic             cmpl_valid_o,
    output logic [4:0]       cmpl_rd_o,
    output bus_simd_t        cmpl_data_o,
    output logic [3:0]       cmpl_xcpt_o,
    output logic             cmpl_timeout_o,
    output bus64_t           cmpl_addr_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [3:0]         retry_q, retry_d;
    req_cpu_dcache_t    mem_q [DEPTH];
    req_cpu_dcache_t    head, entry_in;
    logic               push, pop, clear, complete, timeout, any_xcpt;

    assign head        = mem_q[rd_ptr_q];
    assign req_ready_o = (count_q != CNT_W'(DEPTH));
    assign push        = req_valid_i && req_ready_o && !flush_i;
    assign any_xcpt    = resp_dcache_cpu_i.xcpt_ma_st | resp_dcache_cpu_i.xcpt_ma_ld |
                         resp_dcache_cpu_i.xcpt_pf_st | resp_dcache_cpu_i.xcpt_pf_ld;

    always_comb begin
        entry_in       = req_i;
        entry_in.valid = 1'b0;
        entry_in.kill  = 1'b0;
    end

    always_comb begin
        state_d          = state_q;
        retry_d          = retry_q;
        pop              = 1'b0;
        clear            = 1'b0;
        complete         = 1'b0;
        timeout          = 1'b0;
        req_cpu_dcache_o = '0;
        unique case (state_q)
            IDLE: begin
                if (flush_i)             clear   = 1'b1;
                else if (count_q != '0)  state_d = ISSUE;
            end
            ISSUE: begin
                req_cpu_dcache_o       = head;
                req_cpu_dcache_o.valid = !flush_i;
                req_cpu_dcache_o.kill  = flush_i;
                if (flush_i) begin
                    clear   = 1'b1;
                    state_d = DRAIN;
                end else if (resp_dcache_cpu_i.ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Head fields stay visible so a kill is attributable to the access in flight.
                req_cpu_dcache_o       = head;
                req_cpu_dcache_o.valid = 1'b0;
                req_cpu_dcache_o.kill  = flush_i;
                if (flush_i) begin
                    clear   = 1'b1;
                    state_d = DRAIN;
                end else if (any_xcpt) begin
                    complete = 1'b1;
                    pop      = 1'b1;
                end else if (resp_dcache_cpu_i.nack) begin
                    retry_d = sat_inc4(retry_q);
                    if (retry_q == 4'(MAX_RETRY)) begin
                        complete = 1'b1;
                        timeout  = 1'b1;
                        pop      = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (!resp_dcache_cpu_i.replay && resp_dcache_cpu_i.valid &&
                             resp_dcache_cpu_i.rd == head.rd) begin
                    complete = 1'b1;
                    pop      = 1'b1;
                end
            end
            DRAIN: begin
                if (flush_i)
                    clear = 1'b1;
                else if (resp_dcache_cpu_i.valid || resp_dcache_cpu_i.nack || any_xcpt)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = (count_q > CNT_W'(1)) ? ISSUE : IDLE;
            retry_d = '0;
        end
        if (clear) retry_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            retry_q        <= '0;
            cmpl_valid_o   <= 1'b0;
            cmpl_rd_o      <= '0;
            cmpl_data_o    <= '0;
            cmpl_xcpt_o    <= '0;
            cmpl_timeout_o <= 1'b0;
            cmpl_addr_o    <= '0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            cmpl_valid_o <= complete;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(push);
                rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
                count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
            if (complete) begin
                cmpl_rd_o      <= head.rd;
                cmpl_data_o    <= (head.op == OP_STORE) ? '0 : resp_dcache_cpu_i.data;
                cmpl_xcpt_o    <= {resp_dcache_cpu_i.xcpt_ma_st, resp_dcache_cpu_i.xcpt_ma_ld,
                                   resp_dcache_cpu_i.xcpt_pf_st, resp_dcache_cpu_i.xcpt_pf_ld};
                cmpl_timeout_o <= timeout;
                cmpl_addr_o    <= head.data_rs1;
            end
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end
endmodule

// File: tb/tb_dcache_req_buffer.sv
// Directed bench for dcache_req_buffer: scoreboard of expected completions checked
// on every cycle, plus a second instance with a small retry budget.
module tb_dcache_req_buffer;
    import dcache_req_buffer_pkg::*;

    logic clk, rst, req_valid, req_valid2, flush;
    req_cpu_dcache_t  req, rq1, rq2;
    resp_dcache_cpu_t resp, resp2;
    logic ready1, ready2, cv1, cv2, cto1, cto2;
    logic [4:0] crd1, crd2;
    bus_simd_t cd1, cd2;
    logic [3:0] cx1, cx2;
    bus64_t ca1, ca2;

    typedef struct {
        logic [4:0] rd;
        bus_simd_t  data;
        logic [3:0] xcpt;
        logic       to;
        bus64_t     addr;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    int issues   = 0;

    dcache_req_buffer #(.DEPTH(4), .MAX_RETRY(15)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
        .req_i(req), .flush_i(flush), .req_cpu_dcache_o(rq1), .resp_dcache_cpu_i(resp),
        .cmpl_valid_o(cv1), .cmpl_rd_o(crd1), .cmpl_data_o(cd1), .cmpl_xcpt_o(cx1),
        .cmpl_timeout_o(cto1), .cmpl_addr_o(ca1));

    dcache_req_buffer #(.DEPTH(4), .MAX_RETRY(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid2), .req_ready_o(ready2),
        .req_i(req), .flush_i(flush), .req_cpu_dcache_o(rq2), .resp_dcache_cpu_i(resp2),
        .cmpl_valid_o(cv2), .cmpl_rd_o(crd2), .cmpl_data_o(cd2), .cmpl_xcpt_o(cx2),
        .cmpl_timeout_o(cto2), .cmpl_addr_o(ca2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are inspected at the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (rq1.valid) issues++;
        if (cv1) begin
            if (sb.size() == 0) begin
                check("unexpected_cmpl", cv1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("cmpl_rd", crd1, e.rd);
                check("cmpl_data", cd1, e.data);
                check("cmpl_xcpt", cx1, e.xcpt);
                check("cmpl_timeout", cto1, e.to);
                check("cmpl_addr", ca1, e.addr);
            end
        end
    endtask

    function automatic resp_dcache_cpu_t mk_resp(input logic v, input logic [4:0] rd,
                                                 input bus_simd_t data);
        resp_dcache_cpu_t r;
        r       = '0;
        r.ready = 1'b1;
        r.valid = v;
        r.rd    = rd;
        r.data  = data;
        return r;
    endfunction

    function automatic req_cpu_dcache_t mk_req(input logic [4:0] rd, input mem_op_t op,
                                               input bus64_t addr);
        req_cpu_dcache_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.kill     = 1'b1;
        r.op       = op;
        r.rd       = rd;
        r.mem_size = 3'd3;
        r.data_rs1 = addr;
        r.data_rs2 = ~addr;
        return r;
    endfunction

    task automatic push(input logic [4:0] rd, input mem_op_t op, input bus64_t addr);
        req       = mk_req(rd, op, addr);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic sb_push(input logic [4:0] rd, input bus_simd_t data, input logic [3:0] x,
                           input logic to, input bus64_t addr);
        exp_t e;
        e.rd = rd; e.data = data; e.xcpt = x; e.to = to; e.addr = addr;
        sb.push_back(e);
    endtask

    task automatic wait_issue(input string tag);
        for (int i = 0; i < 10 && !rq1.valid; i++) tick();
        check(tag, rq1.valid, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus64_t     a;
        bus_simd_t  d;
        int         iss;
        logic       done;

        rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; flush = 1'b0;
        req = '0; resp = mk_resp(1'b0, 5'd0, '0); resp2 = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", ready1, 1'b1);
        check("rst_req_zero", rq1, '0);
        check("rst_cmpl_valid", cv1, 1'b0);
        check("rst_cmpl_rd", crd1, 5'd0);
        check("rst_count", dut.count_q, 0);

        // Single load: 2-cycle enqueue-to-issue, response 3 cycles after issue.
        a = 64'h8000_1000;
        push(5'd5, OP_LOAD, a);
        check("t1_no_early_issue", rq1.valid, 1'b0);
        tick();
        check("t1_issue_valid", rq1.valid, 1'b1);
        check("t1_issue_kill", rq1.kill, 1'b0);
        check("t1_issue_rd", rq1.rd, 5'd5);
        check("t1_issue_addr", rq1.data_rs1, a);
        tick();
        check("t1_wait_novalid", rq1.valid, 1'b0);
        tick(); tick();
        resp = mk_resp(1'b1, 5'd5, 128'hDEADBEEF);
        sb_push(5'd5, 128'hDEADBEEF, 4'd0, 1'b0, a);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t1_cmpl_pulse", cv1, 1'b1);
        check("t1_count0", dut.count_q, 0);
        tick();
        check("t1_cmpl_one_cycle", cv1, 1'b0);

        // Nack twice, then respond.
        a = 64'h8000_2000;
        push(5'd3, OP_LOAD, a);
        issues = 0;
        tick();
        check("t2_issue1", rq1.valid, 1'b1);
        for (int n = 0; n < 2; n++) begin
            tick();
            resp      = mk_resp(1'b0, 5'd0, '0);
            resp.nack = 1'b1;
            tick();
            resp = mk_resp(1'b0, 5'd0, '0);
            check("t2_reissue_after_nack", rq1.valid, 1'b1);
        end
        tick();
        resp = mk_resp(1'b1, 5'd3, 128'h1234_5678_9ABC);
        sb_push(5'd3, 128'h1234_5678_9ABC, 4'd0, 1'b0, a);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t2_cmpl", cv1, 1'b1);
        check("t2_issue_total", issues, 3);

        // Fill the queue with the cache not ready; entry 2 is a store.
        resp       = mk_resp(1'b0, 5'd0, '0);
        resp.ready = 1'b0;
        for (int k = 1; k <= 4; k++)
            push(5'(k), (k == 2) ? OP_STORE : OP_LOAD, 64'h9000_0000 + 64'(k * 8));
        check("t3_full_not_ready", ready1, 1'b0);
        check("t3_count4", dut.count_q, 4);
        push(5'd5, OP_LOAD, 64'h9000_0100);
        check("t3_fifth_rejected", dut.count_q, 4);
        check("t3_still_full", ready1, 1'b0);
        resp = mk_resp(1'b0, 5'd0, '0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) wait_issue("t3_first_issue");
            else        check("t3_back_to_back_issue", rq1.valid, 1'b1);
            check("t3_issue_order", rq1.rd, 5'(k));
            tick();
            d    = 128'hA000 + 128'(k);
            resp = mk_resp(1'b1, 5'(k), d);
            sb_push(5'(k), (k == 2) ? '0 : d, 4'd0, 1'b0, 64'h9000_0000 + 64'(k * 8));
            tick();
            resp = mk_resp(1'b0, 5'd0, '0);
            check("t3_cmpl", cv1, 1'b1);
        end
        check("t3_drained", dut.count_q, 0);

        // Replay then valid; a foreign rd during WAIT is ignored.
        a = 64'h8000_7000;
        push(5'd7, OP_LOAD, a);
        wait_issue("t4_issue");
        tick();
        resp        = mk_resp(1'b0, 5'd0, '0);
        resp.replay = 1'b1;
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t4_no_reissue", rq1.valid, 1'b0);
        resp = mk_resp(1'b1, 5'd9, 128'hBAD);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t4_rd_mismatch_ignored", cv1, 1'b0);
        check("t4_still_waiting", rq1.valid, 1'b0);
        resp = mk_resp(1'b1, 5'd7, 128'h7777_0007);
        sb_push(5'd7, 128'h7777_0007, 4'd0, 1'b0, a);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t4_cmpl", cv1, 1'b1);

        // Exception outranks a simultaneous nack.
        a = 64'h8000_6000;
        push(5'd6, OP_LOAD, a);
        wait_issue("t5_issue");
        tick();
        resp            = mk_resp(1'b0, 5'd6, 128'h55);
        resp.nack       = 1'b1;
        resp.xcpt_pf_ld = 1'b1;
        sb_push(5'd6, 128'h55, 4'b0001, 1'b0, a);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t5_xcpt_cmpl", cv1, 1'b1);

        // Flush in WAIT with three entries queued.
        push(5'd10, OP_LOAD, 64'hA10);
        push(5'd11, OP_LOAD, 64'hA11);
        push(5'd12, OP_LOAD, 64'hA12);
        check("t6_count3", dut.count_q, 3);
        flush = 1'b1;
        #1;
        check("t6_kill", rq1.kill, 1'b1);
        check("t6_kill_novalid", rq1.valid, 1'b0);
        tick();
        flush = 1'b0;
        check("t6_count0", dut.count_q, 0);
        check("t6_ready", ready1, 1'b1);
        resp = mk_resp(1'b1, 5'd10, 128'hF00D);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t6_no_cmpl_drain", cv1, 1'b0);
        tick();
        check("t6_no_cmpl_after", cv1, 1'b0);
        check("t6_idle_novalid", rq1.valid, 1'b0);
        push(5'd13, OP_LOAD, 64'hA13);
        tick();
        check("t6_issue_from_idle", rq1.valid, 1'b1);
        check("t6_issue_rd", rq1.rd, 5'd13);
        tick();
        resp = mk_resp(1'b1, 5'd13, 128'h13);
        sb_push(5'd13, 128'h13, 4'd0, 1'b0, 64'hA13);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t6_cmpl", cv1, 1'b1);

        // Reset while waiting; a late response is ignored.
        push(5'd14, OP_LOAD, 64'hA14);
        wait_issue("t7_issue");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_ready", ready1, 1'b1);
        check("t7_count0", dut.count_q, 0);
        resp = mk_resp(1'b1, 5'd14, 128'h14);
        tick();
        resp = mk_resp(1'b0, 5'd0, '0);
        check("t7_late_resp_ignored", cv1, 1'b0);
        tick();
        check("t7_no_issue", rq1.valid, 1'b0);

        // Small retry budget, nack on every attempt.
        resp2       = '0;
        resp2.ready = 1'b1;
        resp2.nack  = 1'b1;
        req        = mk_req(5'd20, OP_LOAD, 64'hB20);
        req_valid2 = 1'b1;
        tick();
        req = mk_req(5'd21, OP_LOAD, 64'hB21);
        tick();
        req_valid2 = 1'b0;
        iss  = 0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (cv2) done = 1'b1;
            else begin
                if (rq2.valid && rq2.rd == 5'd20) iss++;
                tick();
            end
        end
        check("t8_cmpl_seen", done, 1'b1);
        check("t8_issues", iss, 3);
        check("t8_timeout", cto2, 1'b1);
        check("t8_cmpl_rd", crd2, 5'd20);
        check("t8_next_issue", rq2.valid, 1'b1);
        check("t8_next_rd", rq2.rd, 5'd21);
        resp2 = '0;

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
